// File: rtl/layer_pkg.sv
// Shared types and defaults for the layer accumulator: word/accumulator types and FSM states.
package layer_pkg;

  localparam int unsigned W         = 32;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned N_IN_DEF  = 784;
  localparam int unsigned N_OUT_DEF = 128;

  typedef logic signed [W-1:0]     word_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCUM,
    DONE
  } state_t;

  // Index width that stays at least one bit for degenerate single-row layers
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_accum_if.sv
// Weight-stream / activation / result bundle between layer_accum (master) and its environment (slave).
interface layer_accum_if
  import layer_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF
) ();

  localparam int unsigned AW = addr_w(N_IN);

  logic                        go;
  logic                        wt_start;
  logic [N_OUT-1:0][W-1:0]     wt_values;
  logic [AW-1:0]               act_addr;
  word_t                       act_data;
  logic                        busy;
  logic                        done;
  logic [N_OUT-1:0][ACC_W-1:0] result;

  modport master (
    input  go,
    input  wt_values,
    input  act_data,
    output wt_start,
    output act_addr,
    output busy,
    output done,
    output result
  );

  modport slave (
    output go,
    output wt_values,
    output act_data,
    input  wt_start,
    input  act_addr,
    input  busy,
    input  done,
    input  result
  );

endinterface

// File: rtl/mac_lane.sv
// One neuron accumulator: clear, then acc += trunc(act * wt) each enabled cycle, wrapping.
module mac_lane
  import layer_pkg::*;
(
  input  logic  clka,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  input  word_t act,
  input  word_t wt,
  output acc_t  acc
);

  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] prod;
  acc_t                 acc_q;

  // Full-width signed product; only the low ACC_W bits reach the sum
  assign prod = act * wt;

  always_ff @(posedge clka) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/layer_accum.sv
// Dot-product stage for one layer: requests N_IN weight rows and accumulates N_OUT neuron sums.
// Optional LAYER_ACCUM_RELU_EN clamps negative sums to zero when captured into result.
module layer_accum
  import layer_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF
) (
  input logic           clka,
  input logic           rst,
  layer_accum_if.master bus
);

  localparam int unsigned   AW     = addr_w(N_IN);
  localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);

  state_t                      state_q;
  state_t                      state_d;
  logic [AW-1:0]               k_q;
  logic                        lane_clr;
  logic                        lane_en;
  logic                        last_row;
  acc_t                        acc [N_OUT];
  logic [N_OUT-1:0][ACC_W-1:0] result_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_clr = 1'b0;
    lane_en  = 1'b0;
    last_row = (k_q == K_LAST);
    case (state_q)
      IDLE: begin
        if (bus.go) state_d = REQ;
      end
      REQ: begin
        lane_clr = 1'b1;
        state_d  = ACCUM;
      end
      ACCUM: begin
        lane_en = 1'b1;
        if (last_row) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row counter doubles as the activation read index
  always_ff @(posedge clka) begin
    if (rst) begin
      k_q <= '0;
    end else if (state_q == ACCUM) begin
      k_q <= last_row ? '0 : k_q + AW'(1);
    end else if (state_q == REQ) begin
      k_q <= '0;
    end
  end

  for (genvar j = 0; j < int'(N_OUT); j++) begin : g_lane
    mac_lane u_lane (
      .clka (clka),
      .rst  (rst),
      .clr  (lane_clr),
      .en   (lane_en),
      .act  (bus.act_data),
      .wt   (bus.wt_values[j]),
      .acc  (acc[j])
    );
  end

  function automatic acc_t capture(input acc_t a);
`ifdef LAYER_ACCUM_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  // Only the captured copy is clamped; lanes keep their raw sums
  always_ff @(posedge clka) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == DONE) begin
      for (int j = 0; j < int'(N_OUT); j++) begin
        result_q[j] <= capture(acc[j]);
      end
    end
  end

  assign bus.wt_start = (state_q == REQ);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.act_addr = k_q;
  assign bus.result   = result_q;

endmodule
